// File: rtl/fir_requantizer.sv
// fir_requantizer: two-stage requantiser (round/shift, then saturate) with valid/ready
// flow control, a per-sample clip flag, a sticky overflow flag and a non-wrapping clip counter.
module fir_requantizer #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 15,
  parameter int ROUND_MODE = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             sat_flag_o,
  input  logic             clr_i,
  output logic             sticky_ovf_o,
  output logic [CNT_W-1:0] sat_count_o
);

  localparam logic signed [IN_W:0] MaxVal = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MinVal = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]     MaxOut = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]     MinOut = {1'b1, {(OUT_W-1){1'b0}}};

  logic                    pipeEn;
  logic signed [IN_W:0]    xExt;
  logic signed [IN_W:0]    qRound;
  logic [OUT_W-1:0]        clipData;
  logic                    clipSat;
  logic                    outXfer;

  logic                    s1Valid_q, s1Valid_d;
  logic signed [IN_W:0]    s1Data_q, s1Data_d;
  logic                    outValid_q, outValid_d;
  logic [OUT_W-1:0]        outData_q, outData_d;
  logic                    satFlag_q, satFlag_d;
  logic                    stickyOvf_q, stickyOvf_d;
  logic [CNT_W-1:0]        satCount_q, satCount_d;

  assign pipeEn     = !outValid_q || out_ready_i;
  assign in_ready_o = rst_ni && pipeEn;
  assign outXfer    = outValid_q && out_ready_i;

  // One extra sign bit keeps the rounding add from wrapping at the top of the input range.
  assign xExt = {in_data_i[IN_W-1], in_data_i};

  if (SHIFT == 0) begin : g_noShift
    assign qRound = xExt;
  end else begin : g_shift
    localparam logic [IN_W:0] Half = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    logic signed [IN_W:0] qFloor;
    logic signed [IN_W:0] qHalfUp;
    logic                 tieEven;

    assign qFloor  = xExt >>> SHIFT;
    assign qHalfUp = (xExt + $signed(Half)) >>> SHIFT;
    assign tieEven = (in_data_i[SHIFT-1:0] == Half[SHIFT-1:0]) && !qFloor[0];

    always_comb begin
      case (ROUND_MODE)
        0:       qRound = qFloor;
        2:       qRound = tieEven ? qFloor : qHalfUp;
        default: qRound = qHalfUp;
      endcase
    end
  end

  always_comb begin
    clipSat  = 1'b0;
    clipData = s1Data_q[OUT_W-1:0];
    if (s1Data_q > MaxVal) begin
      clipSat  = 1'b1;
      clipData = MaxOut;
    end else if (s1Data_q < MinVal) begin
      clipSat  = 1'b1;
      clipData = MinOut;
    end
  end

  // Both stages advance together or hold together, so nothing is dropped or duplicated.
  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1Data_d   = s1Data_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    satFlag_d  = satFlag_q;
    if (pipeEn) begin
      s1Valid_d  = in_valid_i;
      s1Data_d   = qRound;
      outValid_d = s1Valid_q;
      outData_d  = clipData;
      satFlag_d  = clipSat;
    end
  end

  // A clear and a clipped transfer in the same cycle leave the new event recorded.
  always_comb begin
    stickyOvf_d = clr_i ? 1'b0 : stickyOvf_q;
    satCount_d  = clr_i ? '0 : satCount_q;
    if (outXfer && satFlag_q) begin
      stickyOvf_d = 1'b1;
      if (satCount_d != {CNT_W{1'b1}}) begin
        satCount_d = satCount_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1Valid_q   <= 1'b0;
      s1Data_q    <= '0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      satFlag_q   <= 1'b0;
      stickyOvf_q <= 1'b0;
      satCount_q  <= '0;
    end else begin
      s1Valid_q   <= s1Valid_d;
      s1Data_q    <= s1Data_d;
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      satFlag_q   <= satFlag_d;
      stickyOvf_q <= stickyOvf_d;
      satCount_q  <= satCount_d;
    end
  end

  assign out_valid_o  = outValid_q;
  assign out_data_o   = outData_q;
  assign sat_flag_o   = satFlag_q;
  assign sticky_ovf_o = stickyOvf_q;
  assign sat_count_o  = satCount_q;

endmodule

// File: tb/tb_fir_requantizer.sv
// tb_fir_requantizer: six requantiser instances (three rounding modes at 32->16/SHIFT 15,
// three at 16->16/SHIFT 0) checked against an arithmetic model plus literal vectors.
module tb_fir_requantizer;

  logic clk = 1'b0;
  logic rstN, inValid, outReady, clr;
  logic [31:0] inData;
  logic inValidB, outReadyB, clrB;
  logic [15:0] inDataB;

  logic [5:0]       dutOV, dutIR, dutSat, dutSticky;
  logic [5:0][15:0] dutOD;
  logic [5:0][15:0] dutCnt;
  logic [2:0][3:0]  cntA;

  int testsRun = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gA
    fir_requantizer #(.IN_W(32), .OUT_W(16), .SHIFT(15), .ROUND_MODE(g), .CNT_W(4)) u_dut (
      .clk_i(clk), .rst_ni(rstN), .in_valid_i(inValid), .in_ready_o(dutIR[g]),
      .in_data_i(inData), .out_valid_o(dutOV[g]), .out_ready_i(outReady),
      .out_data_o(dutOD[g]), .sat_flag_o(dutSat[g]), .clr_i(clr),
      .sticky_ovf_o(dutSticky[g]), .sat_count_o(cntA[g]));
    assign dutCnt[g] = {12'b0, cntA[g]};
  end

  for (genvar g = 0; g < 3; g++) begin : gB
    fir_requantizer #(.IN_W(16), .OUT_W(16), .SHIFT(0), .ROUND_MODE(g), .CNT_W(16)) u_dut (
      .clk_i(clk), .rst_ni(rstN), .in_valid_i(inValidB), .in_ready_o(dutIR[g+3]),
      .in_data_i(inDataB), .out_valid_o(dutOV[g+3]), .out_ready_i(outReadyB),
      .out_data_o(dutOD[g+3]), .sat_flag_o(dutSat[g+3]), .clr_i(clrB),
      .sticky_ovf_o(dutSticky[g+3]), .sat_count_o(dutCnt[g+3]));
  end

  task automatic checkOutput(input string name, input int inst, input logic [63:0] act,
                             input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s inst%0d: got %0h, expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int shOf[6]   = '{15, 15, 15, 0, 0, 0};
  int modeOf[6] = '{0, 1, 2, 0, 1, 2};
  int cntMax[6] = '{15, 15, 15, 65535, 65535, 65535};

  function automatic longint floorDiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void requant(input longint x, input int sh, input int mode,
                                  output longint d, output bit s);
    longint p, fl, q;
    p  = longint'(1) << sh;
    fl = floorDiv(x, p);
    if (sh == 0) q = x;
    else if (mode == 0) q = fl;
    else if (mode == 2 && (x - fl * p) == p / 2 && (fl % 2) == 0) q = fl;
    else q = floorDiv(x + p / 2, p);
    s = 1'b0;
    if (q > 32767) begin q = 32767; s = 1'b1; end
    else if (q < -32768) begin q = -32768; s = 1'b1; end
    d = q & 64'hFFFF;
  endfunction

  bit     armed = 1'b0;
  bit     mV1[6], mV2[6], mS1[6], mS2[6], mSticky[6];
  longint mD1[6], mD2[6];
  int     mCnt[6];

  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin
      logic   iv, ordy, cl;
      longint x;
      iv   = (i < 3) ? inValid : inValidB;
      ordy = (i < 3) ? outReady : outReadyB;
      cl   = (i < 3) ? clr : clrB;
      x    = (i < 3) ? longint'($signed(inData)) : longint'($signed(inDataB));
      if (armed) begin
        checkOutput("in_ready", i, 64'(dutIR[i]), 64'(rstN && (!mV2[i] || ordy)));
        checkOutput("out_valid", i, 64'(dutOV[i]), 64'(mV2[i]));
        if (mV2[i]) begin
          checkOutput("out_data", i, 64'(dutOD[i]), mD2[i]);
          checkOutput("sat_flag", i, 64'(dutSat[i]), 64'(mS2[i]));
        end
        checkOutput("sticky_ovf", i, 64'(dutSticky[i]), 64'(mSticky[i]));
        checkOutput("sat_count", i, 64'(dutCnt[i]), 64'(mCnt[i]));
      end
      if (!rstN) begin
        mV1[i] = 0; mV2[i] = 0; mS1[i] = 0; mS2[i] = 0;
        mD1[i] = 0; mD2[i] = 0; mSticky[i] = 0; mCnt[i] = 0;
      end else begin
        if (cl) begin mCnt[i] = 0; mSticky[i] = 0; end
        if (mV2[i] && ordy && mS2[i]) begin
          mSticky[i] = 1;
          if (mCnt[i] < cntMax[i]) mCnt[i]++;
        end
        if (!mV2[i] || ordy) begin
          mV2[i] = mV1[i]; mD2[i] = mD1[i]; mS2[i] = mS1[i];
          mV1[i] = iv;
          if (iv) requant(x, shOf[i], modeOf[i], mD1[i], mS1[i]);
        end
      end
    end
    if (!rstN) armed = 1'b1;
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] vecX[7] = '{32'h00004000, 32'h0000C000, 32'hFFFFC000, 32'h3FFFBFFF,
                           32'h3FFFC000, 32'h7FFFFFFF, 32'h80000000};
  logic [15:0] vecE[7][3] = '{'{16'h0000, 16'h0001, 16'h0000},
                              '{16'h0001, 16'h0002, 16'h0002},
                              '{16'hFFFF, 16'h0000, 16'h0000},
                              '{16'h7FFF, 16'h7FFF, 16'h7FFF},
                              '{16'h7FFF, 16'h7FFF, 16'h7FFF},
                              '{16'h7FFF, 16'h7FFF, 16'h7FFF},
                              '{16'h8000, 16'h8000, 16'h8000}};
  logic vecS[7][3] = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0},
                       '{0, 1, 1}, '{1, 1, 1}, '{1, 1, 1}};
  logic [15:0] sentB[40];

  // Sends one word into the 32-bit group; returns when it should be on out_data.
  task automatic applyStimulus(input logic [31:0] x);
    @(posedge clk); #1;
    inValid = 1'b1;
    inData  = x;
    @(posedge clk); #1;
    inValid = 1'b0;
    checkOutput("latency early", 1, 64'(dutOV[1]), 64'd0);
    @(posedge clk); #1;
    checkOutput("latency", 1, 64'(dutOV[1]), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int idx, rx;
    rstN = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b1; clr = 1'b0;
    inValidB = 1'b0; inDataB = '0; outReadyB = 1'b1; clrB = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      checkOutput("reset out_valid", k, 64'(dutOV[k]), 64'd0);
      checkOutput("reset out_data", k, 64'(dutOD[k]), 64'd0);
      checkOutput("reset sat_flag", k, 64'(dutSat[k]), 64'd0);
      checkOutput("reset sticky", k, 64'(dutSticky[k]), 64'd0);
      checkOutput("reset count", k, 64'(dutCnt[k]), 64'd0);
      checkOutput("reset in_ready", k, 64'(dutIR[k]), 64'd0);
    end
    rstN = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) checkOutput("release in_ready", k, 64'(dutIR[k]), 64'd1);

    // rounding and saturation boundary vectors
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecX[v]);
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("vec%0d data", v), k, 64'(dutOD[k]), 64'(vecE[v][k]));
        checkOutput($sformatf("vec%0d sat", v), k, 64'(dutSat[k]), 64'(vecS[v][k]));
      end
    end

    // backpressure: words 0..9 with out_ready low for cycles 3..7
    idx = 0; rx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      outReady = !(cyc >= 3 && cyc <= 7);
      inValid  = (idx < 10);
      inData   = idx << 15;
      @(negedge clk);
      if (cyc >= 3 && cyc <= 7) checkOutput("stall in_ready", 1, 64'(dutIR[1]), 64'd0);
      if (inValid && dutIR[1]) idx++;
      if (dutOV[1] && outReady) begin
        for (int k = 0; k < 3; k++) checkOutput("bp order", k, 64'(dutOD[k]), 64'(rx));
        rx++;
      end
    end
    checkOutput("bp word count", 1, 64'(rx), 64'd10);
    @(posedge clk); #1;
    inValid = 1'b0; outReady = 1'b1;

    // counter saturation and clear behaviour
    @(posedge clk); #1; rstN = 1'b0;
    @(posedge clk); #1; rstN = 1'b1;
    inValid = 1'b1; inData = 32'h7FFFFFFF;
    repeat (20) @(posedge clk);
    #1; inValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("cnt saturate", k, 64'(dutCnt[k]), 64'd15);
      checkOutput("cnt sticky", k, 64'(dutSticky[k]), 64'd1);
    end
    clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("clr count", k, 64'(dutCnt[k]), 64'd0);
      checkOutput("clr sticky", k, 64'(dutSticky[k]), 64'd0);
    end
    applyStimulus(32'h7FFFFFFF);
    clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("clr+sat count", k, 64'(dutCnt[k]), 64'd1);
      checkOutput("clr+sat sticky", k, 64'(dutSticky[k]), 64'd1);
    end

    // reset with two saturating words in flight
    @(posedge clk); #1; inValid = 1'b1; inData = 32'h7FFFFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1; inValid = 1'b0; rstN = 1'b0;
    @(posedge clk); #1; rstN = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("midrst out_valid", k, 64'(dutOV[k]), 64'd0);
      checkOutput("midrst count", k, 64'(dutCnt[k]), 64'd0);
      checkOutput("midrst sticky", k, 64'(dutSticky[k]), 64'd0);
      checkOutput("midrst in_ready", k, 64'(dutIR[k]), 64'd1);
    end
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("midrst no stale", 1, 64'(dutOV[1]), 64'd0);
    end
    applyStimulus(32'h00028000);
    for (int k = 0; k < 3; k++) checkOutput("post-rst word", k, 64'(dutOD[k]), 64'd5);

    // SHIFT = 0 group: identity with random stalls
    sentB[0] = 16'h7FFF; sentB[1] = 16'h8000; sentB[2] = 16'h0000; sentB[3] = 16'hFFFF;
    for (int j = 4; j < 40; j++) sentB[j] = 16'($urandom_range(0, 65535));
    idx = 0; rx = 0;
    for (int cyc = 0; cyc < 200 && rx < 40; cyc++) begin
      @(posedge clk); #1;
      outReadyB = ($urandom_range(0, 3) != 0);
      inValidB  = (idx < 40);
      inDataB   = sentB[(idx < 40) ? idx : 39];
      @(negedge clk);
      if (inValidB && dutIR[3]) idx++;
      if (dutOV[3] && outReadyB) begin
        for (int k = 3; k < 6; k++) begin
          checkOutput("shift0 data", k, 64'(dutOD[k]), 64'(sentB[rx]));
          checkOutput("shift0 sat", k, 64'(dutSat[k]), 64'd0);
        end
        rx++;
      end
    end
    checkOutput("shift0 word count", 3, 64'(rx), 64'd40);
    @(posedge clk); #1;
    inValidB = 1'b0; outReadyB = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
